// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer: load-use bubbles, branch flushes, data-memory wait freeze and timeout.
// Outputs are combinational from state and inputs. Define HAZ_PERF_CNT_EN for the stall/flush counters.
module hazard_stall_controller #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  ifid_op_i,
  input  logic [4:0]  ifid_rs1_i,
  input  logic [4:0]  ifid_rs2_i,
  input  logic [4:0]  idex_rd_i,
  input  logic        idex_memread_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        bubble_o,
  output logic        pipe_hold_o,
  output logic        err_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    ERR      = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic rs2_used, lu, mem_stall, resolve, lu_act, br_act;

  assign rs2_used  = (ifid_op_i == 7'b0110011) || (ifid_op_i == 7'b0100011) ||
                     (ifid_op_i == 7'b1100011);
  assign lu        = idex_memread_i && (idex_rd_i != 5'd0) &&
                     ((idex_rd_i == ifid_rs1_i) || (rs2_used && (idex_rd_i == ifid_rs2_i)));
  assign mem_stall = dmem_req_i && !dmem_ready_i;

  // Cycles where the pipe is not frozen and the ID-stage hazards get to decide.
  assign resolve = ((state_q == RUN) && !mem_stall) || ((state_q == MEM_WAIT) && dmem_ready_i);
  assign lu_act  = resolve && lu;
  assign br_act  = resolve && !lu && branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    bubble_o     = 1'b0;
    pipe_hold_o  = 1'b0;
    case (state_q)
      IDLE: bubble_o = 1'b1;
      RUN, MEM_WAIT: begin
        if (!resolve) begin
          pipe_hold_o = 1'b1;
        end else if (lu_act) begin
          bubble_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = br_act;
        end
      end
      default: begin
        pipe_hold_o = 1'b1;
        bubble_o    = 1'b1;
      end
    endcase
  end

  assign err_o   = (state_q == ERR);
  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_act && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_act && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller (MAX_WAIT=4): driver queues hand-computed
// expectations per cycle, monitor pops and compares on the falling edge.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic        memread, br, req, rdy;
  logic        pc_write, ifid_write, ifid_flush, bubble, pipe_hold, err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [1:0]  st;
    logic [5:0]  outs;  // {pc_write, ifid_write, ifid_flush, bubble, pipe_hold, err}
    bit          chk_cnt;
    logic [31:0] stall;
    logic [31:0] flush;
    int          id;
  } exp_t;

  exp_t sb[$];

  localparam logic [5:0] O_IDLE = 6'b000100;
  localparam logic [5:0] O_RUN  = 6'b110000;
  localparam logic [5:0] O_LU   = 6'b000100;
  localparam logic [5:0] O_BR   = 6'b111000;
  localparam logic [5:0] O_HOLD = 6'b000010;
  localparam logic [5:0] O_ERR  = 6'b000111;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
  localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  hazard_stall_controller #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .start_i        (start),
    .ifid_op_i      (op),
    .ifid_rs1_i     (rs1),
    .ifid_rs2_i     (rs2),
    .idex_rd_i      (rd),
    .idex_memread_i (memread),
    .branch_taken_i (br),
    .dmem_req_i     (req),
    .dmem_ready_i   (rdy),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .bubble_o       (bubble),
    .pipe_hold_o    (pipe_hold),
    .err_o          (err),
    .state_o        (state),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  always #5 clk = ~clk;

  int step_id = 0;

  task automatic step(input logic r, input logic s, input logic [6:0] o, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic m, input logic t,
                      input logic q, input logic y, input logic [1:0] est, input logic [5:0] eo,
                      input bit cc, input logic [31:0] es, input logic [31:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; start = s; op = o; rs1 = a; rs2 = b; rd = d;
    memread = m; br = t; req = q; rdy = y;
    step_id++;
    e.st = est; e.outs = eo; e.chk_cnt = cc; e.stall = es; e.flush = ef; e.id = step_id;
    sb.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each falling edge.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_write, ifid_write, ifid_flush, bubble, pipe_hold, err};
        tests++;
        if (state !== e.st || act !== e.outs) begin
          failed++;
          $display("FAIL step%0d outputs: state=%b outs=%b, required state=%b outs=%b",
                   e.id, state, act, e.st, e.outs);
        end
        if (e.chk_cnt) begin
          tests++;
          if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
            failed++;
            $display("FAIL step%0d counters: stall=%0d flush=%0d, required stall=%0d flush=%0d",
                     e.id, stall_cnt, flush_cnt, e.stall, e.flush);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    memread = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;

    // reset, then start
    step(0, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b00, O_IDLE, 1, 32'd0, 32'd0);
    step(0, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b00, O_IDLE, 0, 0, 0);
    step(1, 1, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b00, O_IDLE, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b01, O_RUN,  0, 0, 0);
    // load-use via rs1, then clears
    step(1, 0, 7'b0110011, 5, 0, 5, 1, 0, 0, 0, 2'b01, O_LU,  0, 0, 0);
    step(1, 0, 7'b0110011, 5, 0, 5, 0, 0, 0, 0, 2'b01, O_RUN, 0, 0, 0);
    // rd == x0 never stalls
    step(1, 0, 7'b0110011, 0, 0, 0, 1, 0, 0, 0, 2'b01, O_RUN, 0, 0, 0);
    // addi ignores rs2; R-type and store use it
    step(1, 0, 7'b0010011, 1, 5, 5, 1, 0, 0, 0, 2'b01, O_RUN, 0, 0, 0);
    step(1, 0, 7'b0110011, 1, 5, 5, 1, 0, 0, 0, 2'b01, O_LU,  0, 0, 0);
    step(1, 0, 7'b0100011, 1, 5, 5, 1, 0, 0, 0, 2'b01, O_LU,  0, 0, 0);
    // branch flush, and branch suppressed by load-use
    step(1, 0, 7'b1100011, 1, 2, 0, 0, 1, 0, 0, 2'b01, O_BR,  0, 0, 0);
    step(1, 0, 7'b1100011, 5, 2, 5, 1, 1, 0, 0, 2'b01, O_LU,  0, 0, 0);
    step(1, 0, 7'b1100011, 5, 2, 5, 0, 1, 0, 0, 2'b01, O_BR,  0, 0, 0);
    step(1, 0, 7'b0110011, 6, 7, 5, 1, 0, 0, 0, 2'b01, O_RUN, 0, 0, 0);
    // memory wait: ready low three cycles then high
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b01, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b10, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b10, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 1, 2'b10, O_RUN,  0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b01, O_RUN,  0, 0, 0);
    // load-use resolved on the ready cycle of a wait
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b01, O_HOLD, 0, 0, 0);
    step(1, 0, 7'b0110011, 3, 0, 3, 1, 1, 1, 1, 2'b10, O_LU, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b01, O_RUN,  0, 0, 0);
    // start ignored in RUN; counters checked
    step(1, 1, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b01, O_RUN,  1, EXP_STALL, EXP_FLUSH);
    // timeout with MAX_WAIT=4
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b01, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b10, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b10, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b10, O_HOLD, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 1, 0, 2'b11, O_ERR,  0, 0, 0);
    // ERR is sticky regardless of ready/start/hazards
    step(1, 1, 7'h00, 0, 0, 0, 0, 0, 0, 1, 2'b11, O_ERR,  0, 0, 0);
    step(1, 0, 7'b0110011, 5, 0, 5, 1, 1, 0, 0, 2'b11, O_ERR, 0, 0, 0);
    // reset clears error and counters
    step(0, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b00, O_IDLE, 0, 0, 0);
    step(1, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 2'b00, O_IDLE, 1, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
